// File: rtl/match_lock_det.sv
// ---------------------------------------------------------------------------
// match_lock_det
//
// Purpose:
//   Lock detector for a 4-bit pattern comparator. Each valid beat carries the
//   bitwise XNOR of the received and expected nibble (1 = bit equal).
//   - A run of RUN_LEN consecutive full-match beats (xn = 4'b1111) acquires
//     lock.
//   - Once locked, LOSS_LEN consecutive non-full-match beats drop lock.
//   - The popcount of every valid beat is registered as a match score.
//   - Mismatched bits are accumulated in a saturating error counter.
//
// Parameters:
//   RUN_LEN  : full-match beats needed to lock        (1..15)
//   LOSS_LEN : non-full-match beats needed to unlock  (1..15)
//   CNT_W    : width of err_cnt                       (3..32)
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   xn carries a beat this cycle
//   xn        in   [3:0] comparator XNOR result
//   clr       in   synchronous clear of err_cnt only (wins over a beat)
//   lock      out  registered lock indication
//   score     out  [2:0] popcount of the last valid xn
//   score_vld out  one-cycle pulse the cycle after each valid beat
//   err_cnt   out  [CNT_W-1:0] saturating count of mismatched bits
//   lock_chg  out  (only with MATCH_LOCK_IRQ_EN) one-cycle pulse coincident
//                  with every change of lock
//
// Build option:
//   MATCH_LOCK_IRQ_EN  adds the lock_chg output and its register.
// ---------------------------------------------------------------------------
module match_lock_det #(
    parameter int RUN_LEN  = 4,
    parameter int LOSS_LEN = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       xn,
    input  logic             clr,
    output logic             lock,
    output logic [2:0]       score,
    output logic             score_vld,
    output logic [CNT_W-1:0] err_cnt
`ifdef MATCH_LOCK_IRQ_EN
    ,
    output logic             lock_chg
`endif
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [3:0] RUN_L4  = 4'(RUN_LEN);
    localparam logic [3:0] LOSS_L4 = 4'(LOSS_LEN);

    // Number of set bits in the comparator word (0..4).
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Saturating add of a 0..4 increment; a carry out of the CNT_W-bit sum
    // means the true total passed the ceiling, so clamp to all ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [2:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + {{(CNT_W-2){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    // ---- stage p0: beat classification (combinational) ----
    logic       full_p0;
    logic [2:0] pop_p0;
    logic [2:0] bad_p0;

    assign full_p0 = in_valid && (xn == 4'b1111);
    assign pop_p0  = popcount4(xn);
    assign bad_p0  = 3'd4 - pop_p0;

    // Registered state of the detector.
    state_t           state_p1;
    logic [3:0]       run_p1;
    logic [3:0]       miss_p1;
    logic             lock_p1;
    logic [2:0]       score_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] err_p1;

    // Next-state values.
    state_t     state_d;
    logic [3:0] run_d;
    logic [3:0] miss_d;
    logic       lock_d;

    always_comb begin
        state_d = state_p1;
        run_d   = run_p1;
        miss_d  = miss_p1;

        // Idle cycles (in_valid = 0) leave the FSM and its counters frozen.
        if (in_valid) begin
            unique case (state_p1)
                SEARCH: begin
                    if (full_p0) begin
                        run_d   = 4'd1;
                        state_d = (RUN_LEN == 1) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (full_p0) begin
                        run_d = run_p1 + 4'd1;
                        if ((run_p1 + 4'd1) == RUN_L4) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        run_d   = 4'd0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (!full_p0) begin
                        if (LOSS_LEN == 1) begin
                            run_d   = 4'd0;
                            miss_d  = 4'd0;
                            state_d = SEARCH;
                        end else begin
                            miss_d  = 4'd1;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (full_p0) begin
                        miss_d  = 4'd0;
                        state_d = LOCKED;
                    end else if ((miss_p1 + 4'd1) == LOSS_L4) begin
                        run_d   = 4'd0;
                        miss_d  = 4'd0;
                        state_d = SEARCH;
                    end else begin
                        miss_d = miss_p1 + 4'd1;
                    end
                end
                default: begin
                    run_d   = 4'd0;
                    miss_d  = 4'd0;
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // HOLD is still "locked" from the outside: lock only drops when the
    // loss run completes and the FSM returns to SEARCH.
    assign lock_d = (state_d == LOCKED) || (state_d == HOLD);

    // ---- stage p1: FSM, score and error counter registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= SEARCH;
            run_p1   <= 4'd0;
            miss_p1  <= 4'd0;
            lock_p1  <= 1'b0;
        end else begin
            state_p1 <= state_d;
            run_p1   <= run_d;
            miss_p1  <= miss_d;
            lock_p1  <= lock_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_p1 <= 3'd0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                score_p1 <= pop_p0;
            end
        end
    end

    // clr outranks a coincident beat: that beat's mismatches are dropped.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_p1 <= '0;
        end else if (in_valid) begin
            err_p1 <= sat_add(err_p1, bad_p0);
        end
    end

`ifdef MATCH_LOCK_IRQ_EN
    logic chg_p1;

    // Pulses in the same cycle the new lock value appears on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_p1 <= 1'b0;
        end else begin
            chg_p1 <= lock_d ^ lock_p1;
        end
    end

    assign lock_chg = chg_p1;
`else
    // No lock-change pulse in this build.
`endif

    assign lock      = lock_p1;
    assign score     = score_p1;
    assign score_vld = vld_p1;
    assign err_cnt   = err_p1;

endmodule

// File: tb/tb_match_lock_det.sv
// ---------------------------------------------------------------------------
// tb_match_lock_det
//
// Two instances share one stimulus stream:
//   dut_a : RUN_LEN=4, LOSS_LEN=2, CNT_W=8 (defaults)
//   dut_b : RUN_LEN=1, LOSS_LEN=1, CNT_W=3 (boundary configuration)
// A reference model tracks both from the rules of the detector: count
// consecutive full matches while unlocked, consecutive misses while locked,
// popcount score and a clamped error total.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_match_lock_det;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] xn = 4'd0;
    logic       clr = 1'b0;

    logic       a_lock, b_lock;
    logic [2:0] a_score, b_score;
    logic       a_svld, b_svld;
    logic [7:0] a_err;
    logic [2:0] b_err;
`ifdef MATCH_LOCK_IRQ_EN
    logic       a_chg, b_chg;
`endif

    always #5 clk = ~clk;

    match_lock_det #(.RUN_LEN(4), .LOSS_LEN(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .xn(xn), .clr(clr),
        .lock(a_lock), .score(a_score), .score_vld(a_svld), .err_cnt(a_err)
`ifdef MATCH_LOCK_IRQ_EN
        , .lock_chg(a_chg)
`endif
    );

    match_lock_det #(.RUN_LEN(1), .LOSS_LEN(1), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .xn(xn), .clr(clr),
        .lock(b_lock), .score(b_score), .score_vld(b_svld), .err_cnt(b_err)
`ifdef MATCH_LOCK_IRQ_EN
        , .lock_chg(b_chg)
`endif
    );

    int tests_run = 0;
    int fails = 0;

    // Reference model, index 0 = dut_a, 1 = dut_b.
    int m_rl[2]  = '{4, 1};
    int m_ll[2]  = '{2, 1};
    int m_max[2] = '{255, 7};
    bit m_lock[2];
    int m_run[2];
    int m_miss[2];
    int m_err[2];
    bit m_chg[2];
    int m_score;
    bit m_svld;

    task automatic mdl_step(input bit v, input logic [3:0] x, input bit c, input bit r);
        bit full;
        bit prev;
        int pop;
        full = (x == 4'hF);
        pop  = $countones(x);
        for (int d = 0; d < 2; d++) begin
            prev = m_lock[d];
            if (r) begin
                m_lock[d] = 0; m_run[d] = 0; m_miss[d] = 0; m_err[d] = 0;
                m_chg[d] = 0;
            end else begin
                if (v) begin
                    if (!m_lock[d]) begin
                        m_run[d] = full ? m_run[d] + 1 : 0;
                        if (m_run[d] >= m_rl[d]) begin
                            m_lock[d] = 1; m_run[d] = 0; m_miss[d] = 0;
                        end
                    end else begin
                        m_miss[d] = full ? 0 : m_miss[d] + 1;
                        if (m_miss[d] >= m_ll[d]) begin
                            m_lock[d] = 0; m_miss[d] = 0; m_run[d] = 0;
                        end
                    end
                end
                if (c) m_err[d] = 0;
                else if (v) m_err[d] = (m_err[d] + 4 - pop > m_max[d]) ? m_max[d] : m_err[d] + 4 - pop;
                m_chg[d] = (prev != m_lock[d]);
            end
        end
        if (r) begin
            m_score = 0; m_svld = 0;
        end else begin
            m_svld = v;
            if (v) m_score = pop;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic step(input bit v, input logic [3:0] x, input bit c, input bit r);
        in_valid = v; xn = x; clr = c; rst = r;
        @(posedge clk);
        #1;
        mdl_step(v, x, c, r);
        in_valid = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 4'h3, 1, 1);
        tests_run++; if (a_lock !== 1'b0) begin fails++; $display("FAIL reset_lock got=%0b exp=0", a_lock); end
        tests_run++; if (a_score !== 3'd0) begin fails++; $display("FAIL reset_score got=%0d exp=0", a_score); end
        tests_run++; if (a_svld !== 1'b0) begin fails++; $display("FAIL reset_svld got=%0b exp=0", a_svld); end
        tests_run++; if (a_err !== 8'd0 || b_err !== 3'd0) begin fails++; $display("FAIL reset_err got=%0d/%0d exp=0/0", a_err, b_err); end
`ifdef MATCH_LOCK_IRQ_EN
        tests_run++; if (a_chg !== 1'b0) begin fails++; $display("FAIL reset_chg got=%0b exp=0", a_chg); end
`endif
    endtask

    task automatic test_acquire();
        step(0, 4'h0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            step(1, 4'hF, 0, 0);
            tests_run++;
            if (a_lock !== (i == 4)) begin fails++; $display("FAIL acq_lock beat=%0d got=%0b exp=%0b", i, a_lock, (i == 4)); end
            if (i == 1) begin
                tests_run++; if (b_lock !== 1'b1) begin fails++; $display("FAIL acq_b_run1 got=%0b exp=1", b_lock); end
            end
        end
        tests_run++; if (a_score !== 3'd4) begin fails++; $display("FAIL acq_score got=%0d exp=4", a_score); end
        tests_run++; if (a_err !== 8'd0) begin fails++; $display("FAIL acq_err got=%0d exp=0", a_err); end
    endtask

    task automatic test_interrupted();
        logic [3:0] seq [8] = '{4'hF, 4'hF, 4'hF, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF};
        step(0, 4'h0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, seq[i], 0, 0);
            tests_run++;
            if (a_lock !== (i == 7)) begin fails++; $display("FAIL intr_lock beat=%0d got=%0b exp=%0b", i + 1, a_lock, (i == 7)); end
        end
        tests_run++; if (a_err !== 8'd1) begin fails++; $display("FAIL intr_err got=%0d exp=1", a_err); end
    endtask

    task automatic test_loss();
        logic [3:0] seq [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
        bit a_exp [4] = '{1, 1, 1, 0};
        bit b_exp [4] = '{0, 1, 0, 0};
        step(0, 4'h0, 1, 0);
        tests_run++; if (a_err !== 8'd0 || a_lock !== 1'b1) begin fails++; $display("FAIL loss_pre got err=%0d lock=%0b exp err=0 lock=1", a_err, a_lock); end
        for (int i = 0; i < 4; i++) begin
            step(1, seq[i], 0, 0);
            tests_run++;
            if (a_lock !== a_exp[i] || b_lock !== b_exp[i]) begin
                fails++; $display("FAIL loss_lock beat=%0d got=%0b/%0b exp=%0b/%0b", i + 1, a_lock, b_lock, a_exp[i], b_exp[i]);
            end
        end
        tests_run++; if (a_err !== 8'd12) begin fails++; $display("FAIL loss_err got=%0d exp=12", a_err); end
        tests_run++; if (b_err !== 3'd7) begin fails++; $display("FAIL loss_b_sat got=%0d exp=7", b_err); end
    endtask

    task automatic test_gaps_sat();
        step(0, 4'h0, 0, 1);
        step(1, 4'h0, 0, 0);
        tests_run++; if (b_err !== 3'd4) begin fails++; $display("FAIL gap_err1 got=%0d exp=4", b_err); end
        for (int i = 0; i < 5; i++) begin
            step(0, 4'hF, 0, 0);
            tests_run++;
            if (a_lock !== 1'b0 || b_lock !== 1'b0 || a_svld !== 1'b0 || a_score !== 3'd0 || b_err !== 3'd4) begin
                fails++; $display("FAIL gap_frozen idle=%0d got lock=%0b/%0b svld=%0b score=%0d err=%0d exp 0/0 0 0 4",
                                  i, a_lock, b_lock, a_svld, a_score, b_err);
            end
        end
        step(1, 4'h0, 0, 0);
        tests_run++; if (b_err !== 3'd7) begin fails++; $display("FAIL gap_sat got=%0d exp=7", b_err); end
        tests_run++; if (a_err !== 8'd8) begin fails++; $display("FAIL gap_err_a got=%0d exp=8", a_err); end
        step(1, 4'h0, 1, 0);
        tests_run++; if (a_err !== 8'd0 || b_err !== 3'd0) begin fails++; $display("FAIL clr_wins got=%0d/%0d exp=0/0", a_err, b_err); end
        tests_run++; if (a_svld !== 1'b1 || a_score !== 3'd0) begin fails++; $display("FAIL clr_score got svld=%0b score=%0d exp 1 0", a_svld, a_score); end
        step(1, 4'hB, 0, 0);
        tests_run++; if (a_score !== 3'd3 || a_err !== 8'd1) begin fails++; $display("FAIL post_clr got score=%0d err=%0d exp 3 1", a_score, a_err); end
    endtask

    task automatic test_reset_mid();
        step(0, 4'h0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 4'hF, 0, 0);
        step(1, 4'hF, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            step(1, 4'hF, 0, 0);
            tests_run++;
            if (a_lock !== (i == 4)) begin fails++; $display("FAIL rmid_lock beat=%0d got=%0b exp=%0b", i, a_lock, (i == 4)); end
`ifdef MATCH_LOCK_IRQ_EN
            tests_run++;
            if (a_chg !== (i == 4)) begin fails++; $display("FAIL rmid_chg beat=%0d got=%0b exp=%0b", i, a_chg, (i == 4)); end
`endif
        end
    endtask

    task automatic test_random();
        bit v, c, r;
        logic [3:0] x;
        step(0, 4'h0, 0, 1);
        for (int n = 0; n < 800; n++) begin
            v = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 99) == 0);
            step(v, x, c, r);
            tests_run++;
            if (a_lock !== m_lock[0] || b_lock !== m_lock[1]) begin
                fails++; $display("FAIL rnd_lock cyc=%0d got=%0b/%0b exp=%0b/%0b", n, a_lock, b_lock, m_lock[0], m_lock[1]);
            end
            tests_run++;
            if (a_score !== 3'(m_score) || b_score !== 3'(m_score) || a_svld !== m_svld || b_svld !== m_svld) begin
                fails++; $display("FAIL rnd_score cyc=%0d got=%0d/%0d vld=%0b/%0b exp=%0d vld=%0b", n, a_score, b_score, a_svld, b_svld, m_score, m_svld);
            end
            tests_run++;
            if (a_err !== 8'(m_err[0]) || b_err !== 3'(m_err[1])) begin
                fails++; $display("FAIL rnd_err cyc=%0d got=%0d/%0d exp=%0d/%0d", n, a_err, b_err, m_err[0], m_err[1]);
            end
`ifdef MATCH_LOCK_IRQ_EN
            tests_run++;
            if (a_chg !== m_chg[0] || b_chg !== m_chg[1]) begin
                fails++; $display("FAIL rnd_chg cyc=%0d got=%0b/%0b exp=%0b/%0b", n, a_chg, b_chg, m_chg[0], m_chg[1]);
            end
`endif
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_acquire();
        test_interrupted();
        test_loss();
        test_gaps_sat();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
